// File: rtl/i2c_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_sched_pkg
// Description : Shared types and constants for the I2C command scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } state_t;

    typedef logic [23:0] frame_t;

    localparam int N_REQ = 2;

endpackage
`default_nettype wire

// File: rtl/i2c_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : i2c_cmd_scheduler
// Description : Round-robin arbiter sharing one I2C write engine between the
//               initializer and runtime control, with NACK retry.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_cmd_scheduler
    import i2c_sched_pkg::*;
#(
    parameter int N_RETRY = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    input  frame_t           i_frame0,
    input  frame_t           i_frame1,
    output logic [N_REQ-1:0] o_done,
    output logic [N_REQ-1:0] o_err,
    output logic             o_busy,
    output logic             o_eng_start,
    output frame_t           o_eng_frame,
    input  logic             i_eng_done,
    input  logic             i_eng_nack
);

    localparam int                 c_cnt_w   = (N_RETRY > 0) ? $clog2(N_RETRY + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(N_RETRY);

    state_t               r_state, w_state_nxt;
    frame_t               r_frame, w_frame_nxt;
    logic                 r_sel,   w_sel_nxt;
    logic                 r_last,  w_last_nxt;
    logic                 r_err,   w_err_nxt;
    logic [c_cnt_w-1:0]   r_cnt,   w_cnt_nxt;
    logic                 w_grant;

    // On a tie the requester that was not served last wins.
    assign w_grant = (i_req == 2'b11) ? ~r_last : i_req[1];

    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (|i_req) begin
                    w_sel_nxt   = w_grant;
                    w_frame_nxt = w_grant ? i_frame1 : i_frame0;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (i_eng_done) begin
                    if (!i_eng_nack) begin
                        w_err_nxt   = 1'b0;
                        w_state_nxt = REPORT;
                    end else if (r_cnt < c_cnt_max) begin
                        w_cnt_nxt   = r_cnt + c_cnt_w'(1);
                        w_state_nxt = LAUNCH;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = REPORT;
                    end
                end
            end
            REPORT: begin
                w_last_nxt  = r_sel;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_frame <= '0;
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_frame <= w_frame_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs are pure decodes of registered state.
    assign o_busy      = (r_state != IDLE);
    assign o_eng_start = (r_state == LAUNCH);
    assign o_eng_frame = r_frame;
    assign o_done      = (r_state == REPORT) ? {r_sel, ~r_sel} : 2'b00;
    assign o_err       = ((r_state == REPORT) && r_err) ? {r_sel, ~r_sel} : 2'b00;

endmodule
`default_nettype wire

// File: doc/i2c_cmd_scheduler.md
# i2c_cmd_scheduler

Shares one I2C write engine (the 24-bit-frame serializer used for WM8731 codec configuration) between two requesters: the power-up initializer and a runtime control path (volume/mute changes). It arbitrates round-robin, launches the engine, retries NACKed frames up to a fixed count, and returns a per-requester completion pulse with error status. It sits between the requesters and the engine; the engine alone drives sclk/sdat/oen.

## Interface

Parameters:
- N_RETRY, default 3: extra attempts after a NACK; total attempts = N_RETRY+1. N_RETRY=0 is legal.

Ports:
- i_clk  in  1  system clock; single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  2  per-requester request level; bit 0 = initializer, bit 1 = runtime control.
- i_frame0  in  24  requester 0 frame: {device byte, reg/data hi, data lo}; stable while i_req[0] is high.
- i_frame1  in  24  requester 1 frame; same rule.
- o_done  out  2  one-cycle completion pulse for the served requester.
- o_err  out  2  valid only with o_done; 1 = final attempt NACKed.
- o_busy  out  1  high whenever FSM is not IDLE.
- o_eng_start  out  1  one-cycle launch pulse to the engine.
- o_eng_frame  out  24  latched frame presented to the engine; stable from launch to completion.
- i_eng_done  in  1  one-cycle pulse from the engine when a frame ends.
- i_eng_nack  in  1  valid with i_eng_done; 1 = any byte NACKed.

## Operation

- FSM states: IDLE, LAUNCH, WAIT, REPORT.
- IDLE: if any i_req bit is high, select a requester, latch its frame into o_eng_frame, latch the select, clear the retry count, then go to LAUNCH. Otherwise stay.
- Round-robin selection: a last-served pointer resets to 1, so requester 0 wins the first tie. On a tie the requester not last served wins. A single request wins outright.
- LAUNCH: assert o_eng_start for exactly this cycle, then go to WAIT.
- WAIT: ignore everything until i_eng_done.
  - done with nack=0: go to REPORT with err=0.
  - done with nack=1 and retry count < N_RETRY: increment the count, go to LAUNCH, and re-send the same latched frame.
  - done with nack=1 and count = N_RETRY: go to REPORT with err=1.
- REPORT: o_done[sel]=1 and o_err[sel]=err for this cycle only. Update last-served to sel, then go to IDLE.
- Requester protocol: hold i_req high until its o_done pulse. A requester still high in the cycle after REPORT is treated as a new request and competes normally. This gives back-to-back streaming with alternation under contention.
- If i_req drops mid-transaction, the transaction still completes and o_done still pulses.
- A frame change on an unselected requester has no effect. The frame is latched only in IDLE.
- i_eng_done outside WAIT is ignored.
- Retry counter width is $clog2(N_RETRY+1), minimum 1 bit. It never wraps.

## Timing

- Reset values: o_done=0, o_err=0, o_busy=0, o_eng_start=0, o_eng_frame=0. FSM=IDLE, retry count=0, last-served=1.
- All outputs are registered (Moore).
- Request to launch: i_req seen high in IDLE at cycle t gives LAUNCH at t+1, so o_eng_start=1 at t+1.
- Engine completion to report: i_eng_done at cycle d gives o_done at d+1.
- Retry relaunch: NACK done at d gives o_eng_start again at d+1.
- Minimum request-to-request spacing for one requester: done pulse cycle plus 1 (REPORT, then IDLE sampling).
- Reset mid-operation (any state): the next cycle has all outputs at reset values. No o_done is issued for the aborted frame. The engine shares i_rst and aborts too.

## Structure

- Package i2c_sched_pkg holds:
  - state enum (IDLE, LAUNCH, WAIT, REPORT);
  - typedef frame_t = logic [23:0];
  - constant N_REQ = 2.
- Single module. Arbitration is a few lines inline, so no sub-module is warranted.
- The engine is instantiated by the parent, not inside this block.

## Test plan

- Single request: req0 with frame 24'h341E00, engine done (nack=0) 40 cycles after start.
  - Required: exactly one start, o_eng_frame=341E00, o_done=2'b01 one cycle after engine done, o_err=0.
- Simultaneous first requests: both req rise together after reset, frame0=340C00, frame1=340E42.
  - Required: frame0 served first, then frame1. o_done order is 01 then 10.
- Contention streaming: req0 and req1 held high for 4 transactions.
  - Required: service order 0,1,0,1, and every o_eng_start is preceded by the correct latched frame.
- Persistent NACK, N_RETRY=3: every done has nack=1.
  - Required: exactly 4 start pulses with the same frame, then o_done[sel]=1 with o_err[sel]=1.
- Transient NACK: first attempt NACKs, second ACKs.
  - Required: 2 start pulses, o_err=0. The retry count clears for the next request (a following persistent-NACK frame again gets 4 attempts).
- Reset in WAIT: assert i_rst for one cycle mid-frame.
  - Required: next cycle o_busy=0, o_eng_start=0, o_eng_frame=0, and no o_done for the aborted frame.
  - Then: a fresh req1 is served normally, and on a tie requester 0 wins first.
